sync_fifo_prog: RTL

- Single-clock, parametrised successor to the team's dual-clock FIFO.
- Generalises data width and depth, and replaces the fixed almost-threshold gap with runtime-programmable almost_empty/almost_full levels.
- Adds an occupancy count output and sticky overflow/underflow error flags.
- Sits between same-clock producer/consumer stages (DMA, packetiser) where CDC is not needed.

---
 rtl/sync_fifo_prog.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sync_fifo_prog.sv
// ============================================================================
// Module   : sync_fifo_prog
// Purpose  : Single-clock FIFO with programmable almost-empty/almost-full
//            levels, an occupancy count and sticky overflow/underflow flags.
//            Define FIFO_FWFT_EN for first-word-fall-through read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_prog #(
  parameter int fifo_data_size        = 16,
  parameter int fifo_addr_size        = 5,
  parameter int almost_empty_full_gap = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_en,
  input  logic [fifo_data_size-1:0] data_in,
  input  logic                      r_en,
  output logic [fifo_data_size-1:0] data_out,
  input  logic                      cfg_we,
  input  logic [fifo_addr_size:0]   ae_level,
  input  logic [fifo_addr_size:0]   af_level,
  input  logic                      err_clr,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [fifo_addr_size:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int              AW      = fifo_addr_size;
  localparam int              CW      = fifo_addr_size + 1;
  localparam int              DEPTH   = 2 ** fifo_addr_size;
  localparam logic [CW-1:0]   c_depth = CW'(DEPTH);
  localparam logic [CW-1:0]   c_gap   = (almost_empty_full_gap > DEPTH) ? c_depth
                                        : CW'(almost_empty_full_gap);

  logic [fifo_data_size-1:0] r_mem [DEPTH];
  logic [CW-1:0]             r_wr_ptr;
  logic [CW-1:0]             r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic [CW-1:0]             r_ae_lvl;
  logic [CW-1:0]             r_af_lvl;
  logic                      r_empty;
  logic                      r_full;
  logic                      r_almost_empty;
  logic                      r_almost_full;
  logic                      r_overflow;
  logic                      r_underflow;

  logic                      w_wr_acc;
  logic                      w_rd_acc;
  logic [CW-1:0]             w_count_nxt;
  logic [CW-1:0]             w_ae_eff;
  logic [CW-1:0]             w_af_eff;

  function automatic logic [CW-1:0] clamp_level(input logic [CW-1:0] lvl);
    return (lvl > c_depth) ? c_depth : lvl;
  endfunction

  assign w_wr_acc    = w_en && !r_full;
  assign w_rd_acc    = r_en && !r_empty;
  assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

  // Levels being loaded this cycle already steer the flags registered on this edge.
  assign w_ae_eff = cfg_we ? clamp_level(ae_level) : r_ae_lvl;
  assign w_af_eff = cfg_we ? clamp_level(af_level) : r_af_lvl;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_ae_lvl       <= c_gap;
      r_af_lvl       <= c_gap;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count        <= w_count_nxt;
      r_ae_lvl       <= w_ae_eff;
      r_af_lvl       <= w_af_eff;
      r_empty        <= (w_count_nxt == '0);
      r_full         <= (w_count_nxt == c_depth);
      r_almost_empty <= (w_count_nxt <= w_ae_eff);
      r_almost_full  <= (w_count_nxt >= (c_depth - w_af_eff));
      // A fresh error in the same cycle as err_clr must survive the clear.
      if (w_en && r_full) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (r_en && r_empty) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = r_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
`else
  logic [fifo_data_size-1:0] r_data_out;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data_out <= '0;
    end else if (w_rd_acc) begin
      r_data_out <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  assign data_out = r_data_out;
`endif

  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_almost_empty;
  assign almost_full  = r_almost_full;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

`default_nettype wire
